// File: rtl/iadu_fifo.sv
// iadu_fifo: halfword circular queue between fetch and decode.
// Fetched 32-bit words are stored as 16-bit entries so that 16/32-bit
// instructions can be aligned across word boundaries; RVC encodings are
// expanded to their 32-bit equivalents before leaving the block.
module iadu_fifo #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter bit          RVC_EN   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_fetch_valid,
  input  logic [31:0]                i_fetch_data,
  output logic                       o_fetch_ready,
  input  logic                       i_redirect,
  input  logic [31:0]                i_redirect_pc,
  output logic                       o_valid,
  input  logic                       i_decode_ready,
  output logic [31:0]                o_inst,
  output logic [31:0]                o_pc,
  output logic                       o_is_comp,
  output logic                       o_is_illegal,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } state_t;

  // RVC -> RV32I expansion; reserved encodings map to all-zero (illegal).
  function automatic logic [31:0] decompress(input logic [15:0] c);
    logic [31:0] r;
    r = 32'h0;
    case ({c[1:0], c[15:13]})
      5'b00_000: if ({c[12:5]} != 8'h00)
                   r = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000,
                        2'b01, c[4:2], 7'b0010011};
                 else
                   r = 32'h0;
      5'b00_010: r = {5'b00000, c[5], c[12:10], c[6], 2'b00, 2'b01, c[9:7], 3'b010,
                      2'b01, c[4:2], 7'b0000011};
      5'b00_110: r = {5'b00000, c[5], c[12], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010,
                      c[11:10], c[6], 2'b00, 7'b0100011};
      5'b01_000: r = {{7{c[12]}}, c[6:2], c[11:7], 3'b000, c[11:7], 7'b0010011};
      5'b01_001: r = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                      {8{c[12]}}, 5'd1, 7'b1101111};
      5'b01_010: r = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, c[11:7], 7'b0010011};
      5'b01_011: if (c[11:7] == 5'd2)
                   r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000,
                        5'd2, 7'b0010011};
                 else
                   r = {{15{c[12]}}, c[6:2], c[11:7], 7'b0110111};
      5'b01_100: begin
        case (c[11:10])
          2'b00: r = {7'b0000000, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'b0010011};
          2'b01: r = {7'b0100000, c[6:2], 2'b01, c[9:7], 3'b101, 2'b01, c[9:7], 7'b0010011};
          2'b10: r = {{7{c[12]}}, c[6:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'b0010011};
          default: begin
            if (c[12] == 1'b1)
              r = 32'h0;
            else begin
              case (c[6:5])
                2'b00:   r = {7'b0100000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b000, 2'b01, c[9:7], 7'b0110011};
                2'b01:   r = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b100, 2'b01, c[9:7], 7'b0110011};
                2'b10:   r = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b110, 2'b01, c[9:7], 7'b0110011};
                default: r = {7'b0000000, 2'b01, c[4:2], 2'b01, c[9:7], 3'b111, 2'b01, c[9:7], 7'b0110011};
              endcase
            end
          end
        endcase
      end
      5'b01_101: r = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12],
                      {8{c[12]}}, 5'd0, 7'b1101111};
      5'b01_110: r = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, 2'b01, c[9:7], 3'b000,
                      c[11:10], c[4:3], c[12], 7'b1100011};
      5'b01_111: r = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, 2'b01, c[9:7], 3'b001,
                      c[11:10], c[4:3], c[12], 7'b1100011};
      5'b10_000: r = {7'b0000000, c[6:2], c[11:7], 3'b001, c[11:7], 7'b0010011};
      5'b10_010: r = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], 7'b0000011};
      5'b10_100: begin
        if (c[12] == 1'b0) begin
          if (c[6:2] == 5'd0)
            r = {12'h000, c[11:7], 3'b000, 5'd0, 7'b1100111};
          else
            r = {7'b0000000, c[6:2], 5'd0, 3'b000, c[11:7], 7'b0110011};
        end else begin
          if (c[6:2] != 5'd0)
            r = {7'b0000000, c[6:2], c[11:7], 3'b000, c[11:7], 7'b0110011};
          else if (c[11:7] == 5'd0)
            r = 32'h00100073;
          else
            r = {12'h000, c[11:7], 3'b000, 5'd1, 7'b1100111};
        end
      end
      5'b10_110: r = {4'b0000, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

  logic [15:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   pc_r;
  state_t        state_r;
  state_t        state_next_s;

  logic [15:0]   h0_s;
  logic [15:0]   h1_s;
  logic          comp_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] push_n_s;
  logic [CW-1:0] pop_n_s;

  assign h0_s          = mem_r[rd_ptr_r];
  assign h1_s          = mem_r[rd_ptr_r + AW'(1)];
  assign o_fetch_ready = (count_r <= CW'(DEPTH - 2));
  assign o_count       = count_r;
  assign o_pc          = pc_r;

  // Head decode: instruction size, validity and the expanded instruction.
  always_comb begin
    comp_s       = RVC_EN && (h0_s[1:0] != 2'b11);
    o_valid      = 1'b0;
    o_inst       = 32'h0000_0013;
    o_is_comp    = 1'b0;
    o_is_illegal = 1'b0;
    if (comp_s)
      o_valid = ~i_redirect & (count_r >= CW'(1));
    else
      o_valid = ~i_redirect & (count_r >= CW'(2));
    if (!o_valid) begin
      o_inst = 32'h0000_0013;
    end else if (comp_s) begin
      o_is_comp    = 1'b1;
      o_is_illegal = (h0_s == 16'h0000);
      o_inst       = (h0_s == 16'h0000) ? 32'h0 : decompress(h0_s);
    end else begin
      o_inst = {h1_s, h0_s};
    end
  end

  // Handshake qualification; a redirect cancels both sides.
  always_comb begin
    push_s   = i_fetch_valid & o_fetch_ready & ~i_redirect;
    pop_s    = o_valid & i_decode_ready;
    push_n_s = CW'(0);
    pop_n_s  = CW'(0);
    if (push_s)
      push_n_s = (state_r == ST_SKIP) ? CW'(1) : CW'(2);
    else
      push_n_s = CW'(0);
    if (pop_s)
      pop_n_s = comp_s ? CW'(1) : CW'(2);
    else
      pop_n_s = CW'(0);
  end

  // Next-state logic: a misaligned redirect drops the lower half of the next word.
  always_comb begin
    state_next_s = state_r;
    if (i_redirect)
      state_next_s = i_redirect_pc[1] ? ST_SKIP : ST_RUN;
    else if ((state_r == ST_SKIP) && push_s)
      state_next_s = ST_RUN;
    else
      state_next_s = state_r;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_r <= ST_RUN;
    else
      state_r <= state_next_s;
  end

  // Pointers, occupancy and PC; redirect overrides any same-cycle push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      pc_r     <= RESET_PC;
    end else if (i_redirect) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      pc_r     <= i_redirect_pc;
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(push_n_s);
      rd_ptr_r <= rd_ptr_r + AW'(pop_n_s);
      count_r  <= count_r + push_n_s - pop_n_s;
      if (pop_s)
        pc_r <= pc_r + (comp_s ? 32'd2 : 32'd4);
      else
        pc_r <= pc_r;
    end
  end

  // Halfword storage; in SKIP only the upper half of the word is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_r[i] <= 16'h0000;
    end else if (push_s) begin
      if (state_r == ST_SKIP) begin
        mem_r[wr_ptr_r] <= i_fetch_data[31:16];
      end else begin
        mem_r[wr_ptr_r]          <= i_fetch_data[15:0];
        mem_r[wr_ptr_r + AW'(1)] <= i_fetch_data[31:16];
      end
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule

// File: tb/tb_iadu_fifo.sv
module tb_iadu_fifo;

  logic        clk;
  logic        reset_n;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_data;
  logic        o_fetch_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_decode_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_is_comp;
  logic        o_is_illegal;
  logic [3:0]  o_count;

  int n_checks = 0;
  int n_errors = 0;

  iadu_fifo #(.DEPTH(8), .RESET_PC(32'h0), .RVC_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_fetch_valid(i_fetch_valid), .i_fetch_data(i_fetch_data), .o_fetch_ready(o_fetch_ready),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_decode_ready(i_decode_ready),
    .o_inst(o_inst), .o_pc(o_pc), .o_is_comp(o_is_comp),
    .o_is_illegal(o_is_illegal), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_fetch_valid  = 1'b0;
    i_fetch_data   = 32'h0;
    i_redirect     = 1'b0;
    i_redirect_pc  = 32'h0;
    i_decode_ready = 1'b0;
    reset_n        = 1'b0;
    #3;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_fready", {31'b0, o_fetch_ready}, 32'd1);
    check("rst_count", {28'b0, o_count}, 32'd0);
    check("rst_pc", o_pc, 32'h0);
    cycle();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    // 1/2: reset, then a single 32-bit instruction
    do_reset();
    i_fetch_valid = 1'b1; i_fetch_data = 32'h00A00093;
    cycle();
    i_fetch_valid = 1'b0; #1;
    check("t2_valid", {31'b0, o_valid}, 32'd1);
    check("t2_inst", o_inst, 32'h00A00093);
    check("t2_pc", o_pc, 32'h0);
    check("t2_comp", {31'b0, o_is_comp}, 32'd0);
    check("t2_count", {28'b0, o_count}, 32'd2);
    i_decode_ready = 1'b1;
    cycle();
    i_decode_ready = 1'b0; #1;
    check("t2_valid_after", {31'b0, o_valid}, 32'd0);
    check("t2_pc_after", o_pc, 32'h4);
    check("t2_nop", o_inst, 32'h00000013);

    // 3: two compressed instructions in one word
    do_reset();
    i_fetch_valid = 1'b1; i_fetch_data = 32'h45050001;
    cycle();
    i_fetch_valid = 1'b0; #1;
    check("t3_inst0", o_inst, 32'h00000013);
    check("t3_pc0", o_pc, 32'h0);
    check("t3_comp0", {31'b0, o_is_comp}, 32'd1);
    i_decode_ready = 1'b1;
    cycle();
    check("t3_inst1", o_inst, 32'h00100513);
    check("t3_pc1", o_pc, 32'h2);
    check("t3_comp1", {31'b0, o_is_comp}, 32'd1);
    check("t3_count1", {28'b0, o_count}, 32'd1);
    cycle();
    check("t3_valid2", {31'b0, o_valid}, 32'd0);
    check("t3_pc2", o_pc, 32'h4);
    i_decode_ready = 1'b0;

    // 4: 32-bit instruction straddling two words
    do_reset();
    i_fetch_valid = 1'b1; i_fetch_data = 32'h00930001;
    cycle();
    i_fetch_valid = 1'b0; #1;
    check("t4_nop", o_inst, 32'h00000013);
    check("t4_comp", {31'b0, o_is_comp}, 32'd1);
    i_decode_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_wait_valid", {31'b0, o_valid}, 32'd0);
      check("t4_wait_count", {28'b0, o_count}, 32'd1);
    end
    i_fetch_valid = 1'b1; i_fetch_data = 32'h000000A0;
    cycle();
    i_fetch_valid = 1'b0; #1;
    check("t4_valid", {31'b0, o_valid}, 32'd1);
    check("t4_inst", o_inst, 32'h00A00093);
    check("t4_pc", o_pc, 32'h2);
    check("t4_comp32", {31'b0, o_is_comp}, 32'd0);
    check("t4_count", {28'b0, o_count}, 32'd3);
    cycle();
    i_decode_ready = 1'b0; #1;
    check("t4_pc_after", o_pc, 32'h6);
    check("t4_illegal", {31'b0, o_is_illegal}, 32'd1);
    check("t4_ill_inst", o_inst, 32'h0);

    // 5: redirect to a halfword-aligned PC drops the lower half
    do_reset();
    i_redirect = 1'b1; i_redirect_pc = 32'h102; #1;
    check("t5_valid_redir", {31'b0, o_valid}, 32'd0);
    cycle();
    i_redirect = 1'b0;
    i_fetch_valid = 1'b1; i_fetch_data = 32'h00014505;
    cycle();
    i_fetch_valid = 1'b0; #1;
    check("t5_count", {28'b0, o_count}, 32'd1);
    check("t5_inst", o_inst, 32'h00000013);
    check("t5_pc", o_pc, 32'h102);
    check("t5_comp", {31'b0, o_is_comp}, 32'd1);

    // 6: fill to full, refuse the fifth word, redirect at full
    do_reset();
    i_fetch_valid = 1'b1; i_fetch_data = 32'h00010000;
    for (int i = 0; i < 4; i++) cycle();
    check("t6_count_full", {28'b0, o_count}, 32'd8);
    check("t6_fready", {31'b0, o_fetch_ready}, 32'd0);
    i_fetch_data = 32'hFFFFFFFF;
    cycle();
    i_fetch_valid = 1'b0; #1;
    check("t6_refused", {28'b0, o_count}, 32'd8);
    check("t6_illegal", {31'b0, o_is_illegal}, 32'd1);
    check("t6_valid", {31'b0, o_valid}, 32'd1);
    i_redirect = 1'b1; i_redirect_pc = 32'h200; i_decode_ready = 1'b1;
    cycle();
    i_redirect = 1'b0; i_decode_ready = 1'b0; #1;
    check("t6_flush_count", {28'b0, o_count}, 32'd0);
    check("t6_flush_pc", o_pc, 32'h200);
    check("t6_flush_fready", {31'b0, o_fetch_ready}, 32'd1);

    // 7: streaming push+pop with pointer wrap
    do_reset();
    i_fetch_valid = 1'b1; i_fetch_data = 32'h00A00093; i_decode_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    i_fetch_valid = 1'b0; #1;
    check("t7_count", {28'b0, o_count}, 32'd2);
    check("t7_pc", o_pc, 32'd20);
    check("t7_inst", o_inst, 32'h00A00093);
    cycle();
    check("t7_pc_end", o_pc, 32'd24);
    check("t7_count_end", {28'b0, o_count}, 32'd0);
    i_decode_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
